// File: rtl/irl_pkg.sv
// rtl/irl_pkg.sv - shared state encoding and slot codes for the IRL load sequencer
package irl_pkg;

    typedef enum logic [2:0] {
        IRL_IDLE = 3'd0,
        IRL_LOAD = 3'd1,
        IRL_RUN  = 3'd2,
        IRL_DONE = 3'd3
    } irl_state_t;

    localparam logic [2:0] SLOT_A = 3'd0;
    localparam logic [2:0] SLOT_B = 3'd1;
    localparam logic [2:0] SLOT_C = 3'd2;
    localparam logic [2:0] SLOT_D = 3'd3;
    localparam logic [2:0] SLOT_E = 3'd4;

    localparam int IRL_NUM_SLOTS = 5;

endpackage

// File: rtl/irl_slot_counter.sv
// rtl/irl_slot_counter.sv - 3-bit saturating counter with clear and upper limit
module irl_slot_counter (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] limit,
    output logic [2:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= 3'd0;
        end else if (inc && (count < limit)) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/irl_load_sequencer.sv
// rtl/irl_load_sequencer.sv - loads instruction words into slots A..E, then replays them
module irl_load_sequencer
    import irl_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_SLOTS = IRL_NUM_SLOTS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [DATA_W-1:0] data_in,
    input  logic              run_req,
    input  logic              clear,
    output logic              wr_en,
    output logic [2:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [2:0]        rd_addr,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [2:0]        slot_count,
    output logic              full,
    output logic              done,
    output logic              overflow
);

    localparam logic [2:0] SLOT_LIMIT = 3'(NUM_SLOTS);

    irl_state_t state;

    logic accept_load;
    logic start_run;
    logic handshake;
    logic last_slot;

    assign full      = (slot_count == SLOT_LIMIT);
    assign handshake = issue_valid && issue_ready;
    assign last_slot = (rd_addr == slot_count - 3'd1);

    // clear outranks every strobe; run_req outranks load_req in LOAD
    assign accept_load = !clear && load_req &&
                         ((state == IRL_IDLE) ||
                          ((state == IRL_LOAD) && !run_req && !full));
    assign start_run   = !clear && run_req &&
                         ((state == IRL_LOAD) || (state == IRL_DONE));

    irl_slot_counter u_load_count (
        .clk   (clk),
        .clr   (reset || clear),
        .inc   (accept_load),
        .limit (SLOT_LIMIT),
        .count (slot_count)
    );

    // Replay pointer only advances below the last loaded slot, so it never wraps.
    irl_slot_counter u_replay_ptr (
        .clk   (clk),
        .clr   (reset || clear || start_run),
        .inc   ((state == IRL_RUN) && handshake && !last_slot),
        .limit (slot_count),
        .count (rd_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IRL_IDLE;
            wr_en       <= 1'b0;
            wr_addr     <= SLOT_A;
            wr_data     <= '0;
            issue_valid <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wr_en    <= accept_load;
            overflow <= 1'b0;
            if (accept_load) begin
                wr_addr <= slot_count;
                wr_data <= data_in;
            end
            if (clear) begin
                state       <= IRL_IDLE;
                issue_valid <= 1'b0;
                done        <= 1'b0;
            end else begin
                case (state)
                    IRL_IDLE: begin
                        if (load_req) state <= IRL_LOAD;
                    end
                    IRL_LOAD: begin
                        if (run_req) begin
                            state       <= IRL_RUN;
                            issue_valid <= 1'b1;
                            overflow    <= load_req;
                        end else if (load_req && full) begin
                            overflow <= 1'b1;
                        end
                    end
                    IRL_RUN: begin
                        overflow <= load_req;
                        if (handshake && last_slot) begin
                            state       <= IRL_DONE;
                            issue_valid <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                    IRL_DONE: begin
                        overflow <= load_req;
                        if (run_req) begin
                            state       <= IRL_RUN;
                            issue_valid <= 1'b1;
                            done        <= 1'b0;
                        end
                    end
                    default: state <= IRL_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irl_load_sequencer.sv
// tb/tb_irl_load_sequencer.sv - directed self-checking bench for irl_load_sequencer
module tb_irl_load_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req;
    logic [7:0] data_in;
    logic       run_req;
    logic       clear;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] rd_addr;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] slot_count;
    logic       full;
    logic       done;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;

    irl_load_sequencer #(.DATA_W(8), .NUM_SLOTS(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .data_in     (data_in),
        .run_req     (run_req),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .slot_count  (slot_count),
        .full        (full),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] d);
        load_req = 1'b1;
        data_in  = d;
        step();
        load_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load_req = 1'b0; data_in = 8'h00;
        run_req = 1'b0; clear = 1'b0; issue_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // reset state
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_slot_count", slot_count, 0);
        check("rst_full", full, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);

        // run_req in IDLE with nothing loaded is ignored
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("idle_run_ignored", issue_valid, 0);

        // 1: three back-to-back loads
        for (int i = 0; i < 3; i++) begin
            load_req = 1'b1;
            data_in  = 8'h11 * 8'(i + 1);
            step();
            check("t1_wr_en", wr_en, 1);
            check("t1_wr_addr", wr_addr, i);
            check("t1_wr_data", wr_data, 32'h11 * (i + 1));
        end
        load_req = 1'b0;
        step();
        check("t1_wr_en_single", wr_en, 0);
        check("t1_slot_count", slot_count, 3);
        check("t1_full", full, 0);

        // 2: six back-to-back loads, fifth fills, sixth overflows
        do_reset();
        for (int i = 0; i < 6; i++) begin
            load_req = 1'b1;
            data_in  = 8'hA0 + 8'(i);
            step();
            if (i < 5) begin
                check("t2_wr_en", wr_en, 1);
                check("t2_wr_addr", wr_addr, i);
                check("t2_wr_data", wr_data, 32'hA0 + i);
                check("t2_overflow_low", overflow, 0);
            end else begin
                check("t2_wr_en_full", wr_en, 0);
                check("t2_overflow", overflow, 1);
            end
            if (i == 4) check("t2_full", full, 1);
        end
        load_req = 1'b0;
        step();
        check("t2_overflow_pulse", overflow, 0);
        check("t2_slot_count", slot_count, 5);

        // 3: replay three slots with ready held high
        do_reset();
        load_word(8'h01); load_word(8'h02); load_word(8'h03);
        run_req = 1'b1; issue_ready = 1'b1;
        step();
        run_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_issue_valid", issue_valid, 1);
            check("t3_rd_addr", rd_addr, i);
            step();
        end
        check("t3_done", done, 1);
        check("t3_issue_valid_done", issue_valid, 0);
        check("t3_rd_addr_hold", rd_addr, 2);
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        check("t3_done_overflow", overflow, 1);
        check("t3_done_count", slot_count, 3);
        issue_ready = 1'b0;

        // 4: backpressure at rd_addr 1, then replay from DONE
        do_reset();
        load_word(8'h01); load_word(8'h02); load_word(8'h03);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("t4_rd_addr0", rd_addr, 0);
        issue_ready = 1'b1;
        step();
        check("t4_rd_addr1", rd_addr, 1);
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_hold_rd_addr", rd_addr, 1);
            check("t4_hold_valid", issue_valid, 1);
        end
        issue_ready = 1'b1;
        step();
        check("t4_rd_addr2", rd_addr, 2);
        step();
        check("t4_done", done, 1);
        issue_ready = 1'b0;
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("t4_replay_rd_addr", rd_addr, 0);
        check("t4_replay_valid", issue_valid, 1);
        check("t4_replay_done", done, 0);

        // 5: load_req with run_req in LOAD
        do_reset();
        load_word(8'h55); load_word(8'h66);
        load_req = 1'b1; run_req = 1'b1; data_in = 8'h77;
        step();
        load_req = 1'b0; run_req = 1'b0;
        check("t5_wr_en", wr_en, 0);
        check("t5_overflow", overflow, 1);
        check("t5_issue_valid", issue_valid, 1);
        check("t5_slot_count", slot_count, 2);

        // 6: clear mid-RUN, then reset mid-LOAD
        do_reset();
        load_word(8'h01); load_word(8'h02); load_word(8'h03);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t6_clr_valid", issue_valid, 0);
        check("t6_clr_count", slot_count, 0);
        check("t6_clr_done", done, 0);
        check("t6_clr_rd_addr", rd_addr, 0);
        load_word(8'h09); load_word(8'h0A);
        check("t6_load_count", slot_count, 2);
        reset = 1'b1; load_req = 1'b1;
        step();
        reset = 1'b0; load_req = 1'b0;
        check("t6_rst_count", slot_count, 0);
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_valid", issue_valid, 0);
        check("t6_rst_done", done, 0);
        load_word(8'h3C);
        check("t6_after_rst_addr", wr_addr, 0);
        check("t6_after_rst_data", wr_data, 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
